// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result bit-serializer.
//   WORD_W  : width of the ALU result word
//   IDX_W   : width of the bit-index counter (log2 of WORD_W)
//   state_t : serializer FSM states
package alu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 5;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/alu_bit_serializer_if.sv
// Load/stream bundle between the ALU result register, the serializer and its serial consumer.
// Ports (signals):
//   in_word, in_len, in_valid, in_ready : word load handshake
//   abort                               : synchronous flush of the current transfer
//   out_bit, out_last, out_valid, out_ready : serial bit stream handshake
//   done                                : one-cycle pulse after the final bit is accepted
// Modports: master = producer/consumer side (drives loads, accepts bits), slave = serializer.
interface alu_bit_serializer_if;
    import alu_pkg::*;

    logic [WORD_W-1:0] in_word;
    logic [IDX_W-1:0]  in_len;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic              out_bit;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;

    modport master (
        output in_word, in_len, in_valid, abort, out_ready,
        input  in_ready, out_bit, out_valid, out_last, done
    );

    modport slave (
        input  in_word, in_len, in_valid, abort, out_ready,
        output in_ready, out_bit, out_valid, out_last, done
    );

endinterface

// File: rtl/alu_bit_serializer_mux32to1.sv
// 32-to-1 bit multiplexer.
// Ports:
//   in  [31:0] : data word
//   sel [4:0]  : bit index
//   out        : in[sel]
module Mux32to1
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [IDX_W-1:0]  sel,
    output logic              out
);

    assign out = in[sel];

endmodule

// File: rtl/alu_bit_serializer.sv
// Bit-serializer for the 32-bit ALU result: loads a word, then emits one bit per accepted beat
// through an internal 32:1 mux driven by a 5-bit index counter.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : load/stream interface (slave side)
// Parameter:
//   MSB_FIRST : 0 sends bits 0..len, 1 sends bits 31..31-len
module alu_bit_serializer
    import alu_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_bit_serializer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] START_IDX = MSB_FIRST ? LAST_IDX : '0;

    state_t            state_q;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  end_q;
    logic              done_q;
    logic              mux_bit;
    logic              sending;
    logic              is_last;

    assign sending = (state_q == SEND);
    assign is_last = sending && (idx_q == end_q);

    // Abort in IDLE blocks a load by dropping in_ready.
    assign bus.in_ready  = !sending && !bus.abort;
    assign bus.out_valid = sending;
    assign bus.out_last  = is_last;
    assign bus.out_bit   = mux_bit & sending;
    assign bus.done      = done_q;

    Mux32to1 u_mux (
        .in  (word_q),
        .sel (idx_q),
        .out (mux_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            end_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && !bus.abort) begin
                        word_q  <= bus.in_word;
                        idx_q   <= START_IDX;
                        end_q   <= MSB_FIRST ? (LAST_IDX - bus.in_len) : bus.in_len;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // Abort wins over a coincident handshake; that bit is not delivered.
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (bus.out_ready) begin
                        if (is_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else if (MSB_FIRST) begin
                            idx_q <= idx_q - IDX_W'(1);
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
